// File: rtl/slave_apb.sv
// APB completer with a bank of word registers (register 0 is a read-only ID).
// Wait-state insertion is present only when SLAVE_APB_WAIT_EN is defined.
module slave_apb #(
   parameter int unsigned            ADDR_WIDTH  = 32,
   parameter int unsigned            DATA_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = 32'h0002_F000,
   parameter int unsigned            NUM_REGS    = 16,
   parameter int unsigned            WAIT_CYCLES = 2,
   parameter logic [DATA_WIDTH-1:0]  ID_VALUE    = 32'hA2B0_0001
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic [DATA_WIDTH-1:0] pwdata,
   input  logic                  pwrite,
   input  logic                  psel,
   input  logic                  penable,
   output logic [DATA_WIDTH-1:0] prdata,
   output logic                  pready,
   output logic                  pslverr
);

   localparam int unsigned           IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [ADDR_WIDTH-1:0] WIN_BYTES = ADDR_WIDTH'(4 * NUM_REGS);

   if (WAIT_CYCLES > 15) begin : g_bad_wait_cycles
      $error("slave_apb: WAIT_CYCLES must be in 0..15");
   end
   if (NUM_REGS < 2 || NUM_REGS > 1024) begin : g_bad_num_regs
      $error("slave_apb: NUM_REGS must be in 2..1024");
   end

`ifdef SLAVE_APB_WAIT_EN
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   logic [3:0] wait_cnt_q, wait_cnt_d;
`else
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } state_t;
`endif

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
   logic                    pwrite_q, pwrite_d;
   logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];

   logic                    setup;
   logic [ADDR_WIDTH-1:0]   addr_off;
   logic                    addr_ok;
   logic [IDX_W-1:0]        reg_idx;
   logic                    xfer_err;
   logic                    wr_en;
   logic [DATA_WIDTH-1:0]   rd_val;

   assign setup = psel & ~penable;

   // Decode works on the captured address so it is stable through WAIT and RESP.
   always_comb begin
      addr_off = paddr_q - BASE_ADDR;
      addr_ok  = (paddr_q >= BASE_ADDR) && (addr_off < WIN_BYTES) && (paddr_q[1:0] == 2'b00);
      reg_idx  = addr_off[IDX_W+1:2];
      xfer_err = !addr_ok || (pwrite_q && (reg_idx == '0));
      wr_en    = (state_q == ST_RESP) && psel && pwrite_q && !xfer_err;
   end

   always_comb begin
      rd_val = ID_VALUE;
      if (reg_idx != '0) begin
         rd_val = regs_q[reg_idx];
      end
   end

   // State register and captured transfer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         paddr_q  <= '0;
         pwdata_q <= '0;
         pwrite_q <= 1'b0;
`ifdef SLAVE_APB_WAIT_EN
         wait_cnt_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         paddr_q  <= paddr_d;
         pwdata_q <= pwdata_d;
         pwrite_q <= pwrite_d;
`ifdef SLAVE_APB_WAIT_EN
         wait_cnt_q <= wait_cnt_d;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      paddr_d  = paddr_q;
      pwdata_d = pwdata_q;
      pwrite_d = pwrite_q;
`ifdef SLAVE_APB_WAIT_EN
      wait_cnt_d = wait_cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (setup) begin
               paddr_d  = paddr;
               pwdata_d = pwdata;
               pwrite_d = pwrite;
`ifdef SLAVE_APB_WAIT_EN
               wait_cnt_d = WAIT_INIT;
               state_d    = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
`else
               state_d    = ST_RESP;
`endif
            end
         end
`ifdef SLAVE_APB_WAIT_EN
         ST_WAIT: begin
            if (!psel) begin
               state_d = ST_IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q - 4'd1;
               if (wait_cnt_q <= 4'd1) begin
                  state_d = ST_RESP;
               end
            end
         end
`endif
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Register bank; entry 0 is never stored, reads of it return ID_VALUE
   always_comb begin
      regs_d[0] = '0;
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
         regs_d[i] = (wr_en && (reg_idx == IDX_W'(i))) ? pwdata_q : regs_q[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // Outputs decode from state only, so reset clears them asynchronously
   always_comb begin
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = '0;
      if (state_q == ST_RESP) begin
         pready  = 1'b1;
         pslverr = xfer_err;
         if (!pwrite_q && !xfer_err) begin
            prdata = rd_val;
         end
      end
   end

endmodule

// File: tb/tb_slave_apb.sv
// Directed self-checking bench for slave_apb; expected latency follows
// whether SLAVE_APB_WAIT_EN is defined for the build.
module tb_slave_apb;

   localparam int unsigned WAIT_CYCLES = 2;
`ifdef SLAVE_APB_WAIT_EN
   localparam int unsigned LAT = WAIT_CYCLES + 1;
`else
   localparam int unsigned LAT = 1;
`endif
   localparam logic [31:0] ID_VAL = 32'hA2B0_0001;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic        pwrite;
   logic        psel;
   logic        penable;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   slave_apb #(
      .ADDR_WIDTH  (32),
      .DATA_WIDTH  (32),
      .BASE_ADDR   (32'h0002_F000),
      .NUM_REGS    (16),
      .WAIT_CYCLES (WAIT_CYCLES),
      .ID_VALUE    (32'hA2B0_0001)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .paddr   (paddr),
      .pwdata  (pwdata),
      .pwrite  (pwrite),
      .psel    (psel),
      .penable (penable),
      .prdata  (prdata),
      .pready  (pready),
      .pslverr (pslverr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Starts at a negedge with setup, ends at the negedge after pready.
   task automatic apb(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic wr, input logic exp_err, input logic [31:0] exp_rdata);
      int          cyc;
      logic        done;
      logic        err_s;
      logic [31:0] rd_s;
      cyc   = 0;
      done  = 1'b0;
      err_s = 1'bx;
      rd_s  = 'x;
      paddr   = addr;
      pwdata  = wdata;
      pwrite  = wr;
      psel    = 1'b1;
      penable = 1'b0;
      @(negedge clk);
      penable = 1'b1;
      while (!done && cyc < 20) begin
         #1;
         cyc++;
         if (pready === 1'b1) begin
            done  = 1'b1;
            err_s = pslverr;
            rd_s  = prdata;
         end else begin
            @(negedge clk);
         end
      end
      check({tag, "_lat"}, 32'(cyc), LAT);
      check({tag, "_err"}, {31'b0, err_s}, {31'b0, exp_err});
      check({tag, "_rdata"}, rd_s, exp_rdata);
      @(negedge clk);
   endtask

   task automatic idle(input string tag);
      psel    = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
      @(negedge clk);
      #1;
      check({tag, "_idle_pready"}, {31'b0, pready}, 32'h0);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b1;
      paddr   = '0;
      pwdata  = '0;
      pwrite  = 1'b0;
      psel    = 1'b0;
      penable = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("rst_pready",  {31'b0, pready},  32'h0);
      check("rst_pslverr", {31'b0, pslverr}, 32'h0);
      check("rst_prdata",  prdata,           32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      apb("wr_f004", 32'h0002_F004, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
      idle("wr_f004");
      apb("rd_f004", 32'h0002_F004, 32'h0, 1'b0, 1'b0, 32'hDEAD_BEEF);
      idle("rd_f004");

      apb("rd_id", 32'h0002_F000, 32'h0, 1'b0, 1'b0, ID_VAL);
      idle("rd_id");
      apb("wr_id", 32'h0002_F000, 32'h1, 1'b1, 1'b1, 32'h0);
      idle("wr_id");
      apb("rd_id2", 32'h0002_F000, 32'h0, 1'b0, 1'b0, ID_VAL);
      idle("rd_id2");

      apb("rd_oor", 32'h0002_F040, 32'h0, 1'b0, 1'b1, 32'h0);
      idle("rd_oor");
      apb("rd_mis", 32'h0002_F006, 32'h0, 1'b0, 1'b1, 32'h0);
      idle("rd_mis");
      apb("rd_below", 32'h0002_EFFC, 32'h0, 1'b0, 1'b1, 32'h0);
      idle("rd_below");
      apb("rd_last", 32'h0002_F03C, 32'h0, 1'b0, 1'b0, 32'h0);
      idle("rd_last");

      // back-to-back: second setup lands on the cycle after pready
      apb("b2b_wr1", 32'h0002_F008, 32'h11, 1'b1, 1'b0, 32'h0);
      apb("b2b_wr2", 32'h0002_F00C, 32'h22, 1'b1, 1'b0, 32'h0);
      apb("b2b_rd1", 32'h0002_F008, 32'h0, 1'b0, 1'b0, 32'h11);
      apb("b2b_rd2", 32'h0002_F00C, 32'h0, 1'b0, 1'b0, 32'h22);
      idle("b2b");

      // access phase without a setup cycle is ignored
      paddr   = 32'h0002_F018;
      pwdata  = 32'h77;
      pwrite  = 1'b1;
      psel    = 1'b1;
      penable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         check("nosetup_pready", {31'b0, pready}, 32'h0);
      end
      idle("nosetup");
      apb("nosetup_rd", 32'h0002_F018, 32'h0, 1'b0, 1'b0, 32'h0);
      idle("nosetup_rd");

      // psel dropped right after setup aborts the write
      paddr   = 32'h0002_F01C;
      pwdata  = 32'h99;
      pwrite  = 1'b1;
      psel    = 1'b1;
      penable = 1'b0;
      @(negedge clk);
      psel    = 1'b0;
      penable = 1'b0;
      @(negedge clk);
      #1;
      check("abort_pready", {31'b0, pready}, 32'h0);
      @(negedge clk);
      apb("abort_rd", 32'h0002_F01C, 32'h0, 1'b0, 1'b0, 32'h0);
      idle("abort_rd");

      apb("wr_f014", 32'h0002_F014, 32'h5A5A_1234, 1'b1, 1'b0, 32'h0);
      apb("rd_f014", 32'h0002_F014, 32'h0, 1'b0, 1'b0, 32'h5A5A_1234);
      idle("f014");

      // reset during the first access cycle of a write
      paddr   = 32'h0002_F010;
      pwdata  = 32'h55;
      pwrite  = 1'b1;
      psel    = 1'b1;
      penable = 1'b0;
      @(negedge clk);
      penable = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("midrst_pready",  {31'b0, pready},  32'h0);
      check("midrst_pslverr", {31'b0, pslverr}, 32'h0);
      psel    = 1'b0;
      penable = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      apb("midrst_rd", 32'h0002_F010, 32'h0, 1'b0, 1'b0, 32'h0);
      apb("rst_clr_rd", 32'h0002_F004, 32'h0, 1'b0, 1'b0, 32'h0);
      apb("rst_id_rd", 32'h0002_F000, 32'h0, 1'b0, 1'b0, ID_VAL);
      idle("end");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
